// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a table of 2-bit saturating counters indexed by PC.
// The optional gshare indexing (global history XOR PC) is enabled by defining BRANCH_PRED_GSHARE_EN.
module branch_predictor #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 6,
  parameter int PC_LSB     = 2,
  parameter int GHR_BITS   = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lookup_valid,
  input  logic [WIDTH-1:0]    i_lookup_pc,
  output logic                o_pred_valid,
  output logic                o_pred,
  output logic [GHR_BITS-1:0] o_pred_ghr,
  input  logic                i_update_valid,
  input  logic [WIDTH-1:0]    i_update_pc,
  input  logic                i_update_taken,
  input  logic [GHR_BITS-1:0] i_update_ghr
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Valid semantics: a lookup or update is accepted on every edge where its valid is high;
  // there is no ready/backpressure. o_pred_valid pulses one cycle after each accepted lookup,
  // and o_pred/o_pred_ghr hold their last value while it is low.

  logic [1:0]            ctr_q [ENTRIES];
  logic [1:0]            ctr_d;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] up_idx;
  logic                  lk_pred;
  logic                  pred_valid_q;
  logic                  pred_q;
  logic [GHR_BITS-1:0]   pred_ghr_q;
  logic                  unused_bits;

  assign unused_bits = ^{i_lookup_pc[WIDTH-1:PC_LSB+INDEX_BITS], i_lookup_pc[PC_LSB-1:0],
                         i_update_pc[WIDTH-1:PC_LSB+INDEX_BITS], i_update_pc[PC_LSB-1:0]};

`ifdef BRANCH_PRED_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  assign lk_idx = i_lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(ghr_q);
  assign up_idx = i_update_pc[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(i_update_ghr);

  // Lookups in the same cycle as an update see the pre-shift history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ghr_q      <= '0;
      pred_ghr_q <= '0;
    end else begin
      if (i_update_valid) ghr_q <= {ghr_q[GHR_BITS-2:0], i_update_taken};
      if (i_lookup_valid) pred_ghr_q <= ghr_q;
    end
  end
`else
  logic unused_ghr;

  assign unused_ghr = ^i_update_ghr;
  assign lk_idx     = i_lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
  assign up_idx     = i_update_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
  assign pred_ghr_q = '0;
`endif

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (i_update_taken) begin
      if (ctr_q[up_idx] != 2'b11) ctr_d = ctr_q[up_idx] + 2'b01;
    end else begin
      if (ctr_q[up_idx] != 2'b00) ctr_d = ctr_q[up_idx] - 2'b01;
    end
  end

  // Write-first: a lookup hitting the entry being trained sees the trained value.
  always_comb begin
    lk_pred = ctr_q[lk_idx][1];
    if (i_update_valid && (up_idx == lk_idx)) lk_pred = ctr_d[1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (i_update_valid) begin
      ctr_q[up_idx] <= ctr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pred_valid_q <= 1'b0;
      pred_q       <= 1'b0;
    end else begin
      pred_valid_q <= i_lookup_valid;
      if (i_lookup_valid) pred_q <= lk_pred;
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred       = pred_q;
  assign o_pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// against a counter-table model; builds for either value of BRANCH_PRED_GSHARE_EN.
module tb_branch_predictor;

  localparam int W  = 32;
  localparam int IB = 6;
  localparam int PL = 2;
  localparam int GB = 6;
  localparam int N  = 1 << IB;
`ifdef BRANCH_PRED_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_valid = 1'b0;
  logic [W-1:0]  lookup_pc = '0;
  logic          pred_valid;
  logic          pred;
  logic [GB-1:0] pred_ghr;
  logic          update_valid = 1'b0;
  logic [W-1:0]  update_pc = '0;
  logic          update_taken = 1'b0;
  logic [GB-1:0] update_ghr = '0;

  int total = 0;
  int bad   = 0;

  // Reference model: counter strength as an integer 0..3, history as an integer.
  int ctr_m [N];
  int ghr_m;
  int exp_pred;
  int exp_ghr;

  always #5 clk = ~clk;

  branch_predictor #(.WIDTH(W), .INDEX_BITS(IB), .PC_LSB(PL), .GHR_BITS(GB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc),
    .o_pred_valid(pred_valid), .o_pred(pred), .o_pred_ghr(pred_ghr),
    .i_update_valid(update_valid), .i_update_pc(update_pc),
    .i_update_taken(update_taken), .i_update_ghr(update_ghr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int table_index(input logic [W-1:0] pc, input int hist);
    return ((int'(pc) >>> PL) % N) ^ hist;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) ctr_m[i] = 1;
    ghr_m    = 0;
    exp_pred = 0;
    exp_ghr  = 0;
  endtask

  // One clock: drive at negedge, advance the model at the edge, check just after it.
  task automatic step(input bit lv, input logic [W-1:0] lpc, input bit uv,
                      input logic [W-1:0] upc, input bit ut, input logic [GB-1:0] ughr);
    int hist, li, ui;
    @(negedge clk);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_ghr = ughr;
    @(posedge clk);
    hist = GSHARE ? ghr_m : 0;
    li   = table_index(lpc, hist);
    ui   = table_index(upc, GSHARE ? int'(ughr) : 0);
    if (uv) begin
      ctr_m[ui] = ut ? ((ctr_m[ui] == 3) ? 3 : ctr_m[ui] + 1)
                     : ((ctr_m[ui] == 0) ? 0 : ctr_m[ui] - 1);
      if (GSHARE) ghr_m = ((ghr_m << 1) | int'(ut)) % (1 << GB);
    end
    if (lv) begin
      exp_pred = (ctr_m[li] >= 2) ? 1 : 0;
      exp_ghr  = hist;
    end
    #1;
    check("pred_valid", 32'(pred_valid), 32'(lv));
    check("pred", 32'(pred), 32'(exp_pred));
    check("pred_ghr", 32'(pred_ghr), 32'(exp_ghr));
  endtask

  task automatic lookup(input logic [W-1:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic train(input logic [W-1:0] pc, input bit taken, input int times);
    for (int i = 0; i < times; i++) step(1'b0, '0, 1'b1, pc, taken, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lookup_valid = 1'b0; update_valid = 1'b0;
    #1;
    model_reset();
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred", 32'(pred), 32'd0);
    check("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: fresh counter is weakly not-taken
    lookup(32'h100);
    check("t1_pred", 32'(pred), 32'd0);

    // 2: train toward taken then back down
    train(32'h100, 1'b1, 1);
    lookup(32'h100);
    train(32'h100, 1'b1, 2);
    train(32'h100, 1'b0, 1);
    lookup(32'h100);
    train(32'h100, 1'b0, 2);
    lookup(32'h100);

    // 3: saturation at both ends
    train(32'h200, 1'b0, 5);
    train(32'h200, 1'b1, 1);
    lookup(32'h200);
    train(32'h200, 1'b1, 5);
    train(32'h200, 1'b0, 1);
    lookup(32'h200);

    // 4: same-cycle lookup and update on the same entry
    do_reset();
    step(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, '0);
`ifndef BRANCH_PRED_GSHARE_EN
    check("t4_write_first", 32'(pred), 32'd1);
`endif

    // 5: aliasing through ignored upper PC bits
    do_reset();
    train(32'h004, 1'b1, 2);
    lookup(32'h104);
`ifndef BRANCH_PRED_GSHARE_EN
    check("t5_alias", 32'(pred), 32'd1);
`endif

    // 6: history capture, then reset mid-sequence
    do_reset();
    train(32'h040, 1'b1, 2);
    train(32'h040, 1'b0, 1);
    lookup(32'h080);
`ifdef BRANCH_PRED_GSHARE_EN
    check("t6_ghr", 32'(pred_ghr), 32'h06);
`else
    check("t6_ghr_tied", 32'(pred_ghr), 32'h00);
`endif
    do_reset();
    lookup(32'h040);
    check("t6_after_rst", 32'(pred), 32'd0);

    // Randomized traffic on a small PC pool so collisions and aliasing are frequent
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] lpc, upc;
      bit lv, uv;
      lpc = W'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      upc = ($urandom_range(0, 3) == 0) ? lpc
          : W'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      lv = ($urandom_range(0, 3) != 0);
      uv = ($urandom_range(0, 2) != 0);
      if (n == 1500) do_reset();
      step(lv, lpc, uv, upc, 1'($urandom_range(0, 1)), GB'($urandom_range(0, (1 << GB) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
